// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
//   Shared types and constants for the divider issue/capture stage.
//   - DIV_WIDTH      : default operand width of the divider datapath
//   - div_operands_t : one dividend/divisor pair {a, b}
//   - div_result_t   : one captured result {quotient, remainder, div0}
//   - out_state_t    : state of the output holding register
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 4;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] a;
        logic [DIV_WIDTH-1:0] b;
    } div_operands_t;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] quotient;
        logic [DIV_WIDTH-1:0] remainder;
        logic                 div0;
    } div_result_t;

    // The output register is a two-state machine; out_valid is the state bit.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/div_issue_stage_fifo.sv
// ---------------------------------------------------------------------------
// div_operand_fifo
//   Operand FIFO for the divider issue stage. Head entry is read
//   combinationally from storage (no output register).
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     push       : write wr_data at the write pointer (caller guards with !full)
//     wr_data    : packed operand pair
//     pop        : retire the head entry (caller guards with !empty)
//     rd_data    : head entry, valid when !empty
//     count      : current occupancy, 0..DEPTH
//     full/empty : occupancy flags derived from count
// ---------------------------------------------------------------------------
module div_operand_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Storage is not reset; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/div_issue_stage.sv
// ---------------------------------------------------------------------------
// div_issue_stage
//   Sequential front/back end for a combinational divider. Operand pairs
//   enter over a valid/ready handshake into a FIFO; the FIFO head drives the
//   divider; the divider outputs are captured into an output holding
//   register presented over a second valid/ready handshake.
//
//   Handshakes: a transfer happens on a rising edge where valid && ready are
//   both high. in_ready depends only on FIFO occupancy; out_valid is the
//   output-register state and, once high, holds its data until out_ready.
//
//   Ports:
//     in_valid/in_ready/in_a/in_b          : operand input handshake
//     div_a/div_b                          : to divider A_input/B_input
//     div_quotient/div_remainder           : from divider
//     out_valid/out_ready/out_quotient/
//       out_remainder/out_div0             : result output handshake
//     count                                : FIFO occupancy
//
//   Build option: DIV_ISSUE_DIV0_TRAP_EN -- when defined, a zero divisor
//   yields out_div0=1, quotient all-ones, remainder = dividend, ignoring the
//   divider outputs. When undefined, out_div0 stays 0 and divider outputs
//   are captured as-is.
// ---------------------------------------------------------------------------
module div_issue_stage
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    output logic [WIDTH-1:0]       div_a,
    output logic [WIDTH-1:0]       div_b,
    input  logic [WIDTH-1:0]       div_quotient,
    input  logic [WIDTH-1:0]       div_remainder,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_quotient,
    output logic [WIDTH-1:0]       out_remainder,
    output logic                   out_div0,
    output logic [$clog2(DEPTH):0] count
);
    logic [2*WIDTH-1:0] head;
    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               load;

    out_state_t         state;
    out_state_t         state_next;

    logic [WIDTH-1:0]   cap_quotient;
    logic [WIDTH-1:0]   cap_remainder;
    logic               cap_div0;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign load     = !fifo_empty && (!out_valid || out_ready);

    div_operand_fifo #(
        .DATA_W (2*WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data ({in_a, in_b}),
        .pop     (load),
        .rd_data (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_a = head[2*WIDTH-1:WIDTH];
    assign head_b = head[WIDTH-1:0];

    // Idle divider inputs are 0/1 so the divider never sees X or a zero divisor.
    assign div_a = fifo_empty ? '0          : head_a;
    assign div_b = fifo_empty ? WIDTH'(1)   : head_b;

    // Value captured on a load.
    always_comb begin
        cap_quotient  = div_quotient;
        cap_remainder = div_remainder;
        cap_div0      = 1'b0;
`ifdef DIV_ISSUE_DIV0_TRAP_EN
        if (head_b == '0) begin
            cap_quotient  = '1;
            cap_remainder = head_a;
            cap_div0      = 1'b1;
        end
`endif
    end

    // Output register state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= OUT_EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            OUT_EMPTY: if (load) state_next = OUT_FULL;
            OUT_FULL: begin
                if (load)           state_next = OUT_FULL;
                else if (out_ready) state_next = OUT_EMPTY;
            end
            default:   state_next = OUT_EMPTY;
        endcase
    end

    assign out_valid = (state == OUT_FULL);

    // Result fields change only on a load; otherwise they hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_quotient  <= '0;
            out_remainder <= '0;
            out_div0      <= 1'b0;
        end else if (load) begin
            out_quotient  <= cap_quotient;
            out_remainder <= cap_remainder;
            out_div0      <= cap_div0;
        end
    end

endmodule

// File: tb/tb_div_issue_stage.sv
module tb_div_issue_stage;

  localparam int W = 4;
  localparam int RW = 2 * W + 1;  // {quotient, remainder, div0}

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic [W-1:0] div_quotient;
  logic [W-1:0] div_remainder;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;
  logic         out_div0;
  logic [2:0]   count;

  int n_cmp = 0;
  int n_err = 0;
  logic [RW-1:0] exp_q[$];

  div_issue_stage #(.WIDTH(W), .DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .div_a         (div_a),
    .div_b         (div_b),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_div0      (out_div0),
    .count         (count)
  );

  // Stand-in for the combinational divider; a zero divisor gives 0/0.
  assign div_quotient  = (div_b == '0) ? '0 : div_a / div_b;
  assign div_remainder = (div_b == '0) ? '0 : div_a % div_b;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  // Sampled mid-cycle; a result with out_valid && out_ready transfers at the next edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {out_quotient, out_remainder, out_div0}, '1);
      end else begin
        check("result", {out_quotient, out_remainder, out_div0}, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  // q/r are the hand-computed divider results for a/b.
  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] q, input logic [W-1:0] r);
    logic [RW-1:0] e;
    int waited;
    e = {q, r, 1'b0};
`ifdef DIV_ISSUE_DIV0_TRAP_EN
    if (b == '0) e = {{W{1'b1}}, a, 1'b1};
`endif
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    waited = 0;
    while (!in_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!in_ready) begin
      check("push_timeout", 0, 1);
    end else begin
      exp_q.push_back(e);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      step();
      t++;
    end
    check("drain", exp_q.size(), 0);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", out_quotient, 0);
    check("rst_remainder", out_remainder, 0);
    check("rst_div0", out_div0, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("idle_div_a", div_a, 0);
    check("idle_div_b", div_b, 1);

    // Single 15/1: latency of one edge after acceptance
    out_ready = 1'b1;
    push_pair(4'd15, 4'd1, 4'd15, 4'd0);
    check("t1_count_after_push", count, 1);
    check("t1_not_yet_valid", out_valid, 0);
    check("t1_div_a", div_a, 15);
    check("t1_div_b", div_b, 1);
    step();
    check("t1_out_valid", out_valid, 1);
    check("t1_quotient", out_quotient, 15);
    check("t1_remainder", out_remainder, 0);
    check("t1_count_zero", count, 0);
    step();
    check("t1_valid_drops", out_valid, 0);

    // Back-to-back 13/4, 9/2, 7/7: one result per cycle
    push_pair(4'd13, 4'd4, 4'd3, 4'd1);
    check("t2_count_a", count, 1);
    push_pair(4'd9, 4'd2, 4'd4, 4'd1);
    check("t2_valid_a", out_valid, 1);
    check("t2_q_a", out_quotient, 3);
    check("t2_count_b", count, 1);
    push_pair(4'd7, 4'd7, 4'd1, 4'd0);
    check("t2_q_b", out_quotient, 4);
    step();
    check("t2_q_c", out_quotient, 1);
    check("t2_r_c", out_remainder, 0);
    check("t2_count_c", count, 0);
    step();

    // Back-pressure: fill output register plus four FIFO entries
    out_ready = 1'b0;
    push_pair(4'd14, 4'd3, 4'd4, 4'd2);
    push_pair(4'd8,  4'd2, 4'd4, 4'd0);
    push_pair(4'd11, 4'd5, 4'd2, 4'd1);
    push_pair(4'd6,  4'd0, 4'd0, 4'd0);   // zero divisor
    push_pair(4'd12, 4'd7, 4'd1, 4'd5);
    check("t3_count_full", count, 4);
    check("t3_in_ready_low", in_ready, 0);
    check("t3_out_valid", out_valid, 1);
    check("t3_hold_q", out_quotient, 4);
    in_valid = 1'b1;
    in_a = 4'd10;
    in_b = 4'd3;
    step();
    step();
    check("t3_still_full", count, 4);
    check("t3_hold_r", out_remainder, 2);
    out_ready = 1'b1;
    push_pair(4'd10, 4'd3, 4'd3, 4'd1);
    check("t3_push_pop_count", count, 3);
    wait_drain();

    // Simultaneous push/pop at count=2
    out_ready = 1'b0;
    push_pair(4'd5,  4'd2, 4'd2, 4'd1);
    push_pair(4'd9,  4'd3, 4'd3, 4'd0);
    push_pair(4'd15, 4'd4, 4'd3, 4'd3);
    check("t4_count_two", count, 2);
    out_ready = 1'b1;
    push_pair(4'd7, 4'd2, 4'd3, 4'd1);
    check("t4_count_stays", count, 2);
    wait_drain();

    // Divide by zero on its own
    push_pair(4'd6, 4'd0, 4'd0, 4'd0);
    step();
    check("t5_valid", out_valid, 1);
`ifdef DIV_ISSUE_DIV0_TRAP_EN
    check("t5_div0", out_div0, 1);
    check("t5_q", out_quotient, 4'hF);
    check("t5_r", out_remainder, 6);
`else
    check("t5_div0", out_div0, 0);
    check("t5_q", out_quotient, 0);
    check("t5_r", out_remainder, 0);
`endif
    wait_drain();

    // Reset mid-operation with entries queued
    out_ready = 1'b0;
    push_pair(4'd8,  4'd3, 4'd2, 4'd2);
    push_pair(4'd13, 4'd2, 4'd6, 4'd1);
    push_pair(4'd4,  4'd4, 4'd1, 4'd0);
    push_pair(4'd11, 4'd3, 4'd3, 4'd2);
    check("t6_count_three", count, 3);
    check("t6_valid_before", out_valid, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_q", out_quotient, 0);
    check("t6_async_r", out_remainder, 0);
    check("t6_async_div0", out_div0, 0);
    check("t6_async_count", count, 0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    check("t6_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t6_no_stale", out_valid, 0);
    end
    check("t6_count_end", count, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
